// File: rtl/pulse_stretch_pkg.sv
// ---------------------------------------------------------------------------
// pulse_stretch_pkg
// Shared types and helpers for the multi-channel pulse stretcher.
//   chan_state_t  : per-channel FSM state (IDLE / STRETCH / HOLDOFF)
//   HCNT_W_MIN    : smallest legal hold-off counter width
//   hcnt_width()  : hold-off counter width for a given HOLDOFF length,
//                   clog2-based and never narrower than HCNT_W_MIN
// ---------------------------------------------------------------------------
package pulse_stretch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_STRETCH = 2'd1,
      ST_HOLDOFF = 2'd2
   } chan_state_t;

   localparam int HCNT_W_MIN = 1;

   // The hold-off counter runs from HOLDOFF-1 down to 0, so clog2(HOLDOFF)
   // bits suffice; HOLDOFF of 0 or 1 still needs a 1-bit counter to exist.
   function automatic int hcnt_width(input int holdoff);
      int w;
      w = $clog2(holdoff);
      return (w < HCNT_W_MIN) ? HCNT_W_MIN : w;
   endfunction

endpackage

// File: rtl/stretch_channel.sv
// ---------------------------------------------------------------------------
// stretch_channel
// One channel of the pulse stretcher: FSM, length counter, hold-off counter,
// done strobe and sticky dropped flag.
// Parameters:
//   CNT_W   : length counter width (len = 0 means 2^CNT_W cycles)
//   HOLDOFF : forced-low cycles after each pulse (0 = no hold-off window)
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   trig         : single-cycle rising-edge indication for this channel
//   len          : pulse length, sampled only at load/reload
//   retrig       : 1 = a trigger during a pulse restarts it, 0 = it is dropped
//   clr_dropped  : synchronous clear of the dropped flag
//   pulse_out    : registered stretched pulse
//   done         : high on the final high cycle of pulse_out
//   dropped      : sticky flag, set when a trigger is ignored
//   active       : channel is not idle
// ---------------------------------------------------------------------------
module stretch_channel
   import pulse_stretch_pkg::*;
#(
   parameter int CNT_W   = 16,
   parameter int HOLDOFF = 0
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             trig,
   input  logic [CNT_W-1:0] len,
   input  logic             retrig,
   input  logic             clr_dropped,
   output logic             pulse_out,
   output logic             done,
   output logic             dropped,
   output logic             active
);

   localparam int HCNT_W = hcnt_width(HOLDOFF);

   chan_state_t      state, state_next;
   logic [CNT_W-1:0]  cnt, cnt_next;
   logic [HCNT_W-1:0] hcnt, hcnt_next;
   logic              drop_evt;
   logic              dropped_next;

   // State and counter registers. pulse_out is registered from the next
   // state so it is glitch-free and drops asynchronously on reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         hcnt      <= '0;
         pulse_out <= 1'b0;
         dropped   <= 1'b0;
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         hcnt      <= hcnt_next;
         pulse_out <= (state_next == ST_STRETCH);
         dropped   <= dropped_next;
      end
   end

   // Next-state logic. cnt holds the number of remaining high cycles minus
   // one, so loading len-1 (wrapping for len = 0) yields exactly len cycles.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      hcnt_next  = hcnt;
      drop_evt   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (trig) begin
               state_next = ST_STRETCH;
               cnt_next   = len - CNT_W'(1);
            end
         end
         ST_STRETCH: begin
            if (trig && retrig) begin
               cnt_next = len - CNT_W'(1);
            end else begin
               drop_evt = trig;
               if (cnt == '0) begin
                  if (HOLDOFF > 0) begin
                     state_next = ST_HOLDOFF;
                     hcnt_next  = HCNT_W'(HOLDOFF - 1);
                  end else begin
                     state_next = ST_IDLE;
                  end
               end else begin
                  cnt_next = cnt - CNT_W'(1);
               end
            end
         end
         ST_HOLDOFF: begin
            drop_evt = trig;
            if (hcnt == '0) begin
               state_next = ST_IDLE;
            end else begin
               hcnt_next = hcnt - HCNT_W'(1);
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      // A drop in the same cycle as a clear must leave the flag set.
      if (drop_evt) begin
         dropped_next = 1'b1;
      end else if (clr_dropped) begin
         dropped_next = 1'b0;
      end else begin
         dropped_next = dropped;
      end
   end

   // done depends on the current trigger: a reload on the last cycle
   // extends the pulse, so that cycle is no longer the final one.
   always_comb begin
      done   = (state == ST_STRETCH) && (cnt == '0) && !(trig && retrig);
      active = (state != ST_IDLE);
   end

endmodule

// File: rtl/multi_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// multi_pulse_stretcher
// Multi-channel runtime-programmable pulse stretcher. Each channel turns a
// rising edge on pulse_in into a pulse of len cycles (0 = 2^CNT_W).
// Optional build macro:
//   PULSE_STRETCH_SYNC_EN : adds a 2-flop synchronizer (reset to 1) on each
//                           pulse_in bit; latencies grow by 2 cycles.
// Parameters: CHANNELS, CNT_W, HOLDOFF
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   pulse_in     : trigger inputs, one per channel
//   len          : shared pulse length
//   retrig       : retriggerable (1) / non-retriggerable (0) mode
//   clr_dropped  : clears all dropped flags
//   pulse_out    : stretched pulses (registered)
//   done         : strobe on each channel's last high cycle
//   dropped      : sticky per-channel ignored-trigger flags
//   busy         : any channel not idle
// ---------------------------------------------------------------------------
module multi_pulse_stretcher
   import pulse_stretch_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 16,
   parameter int HOLDOFF  = 0
)(
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] pulse_in,
   input  logic [CNT_W-1:0]    len,
   input  logic                retrig,
   input  logic                clr_dropped,
   output logic [CHANNELS-1:0] pulse_out,
   output logic [CHANNELS-1:0] done,
   output logic [CHANNELS-1:0] dropped,
   output logic                busy
);

   logic [CHANNELS-1:0] pulse_sync;
   logic [CHANNELS-1:0] prev;
   logic [CHANNELS-1:0] trig;
   logic [CHANNELS-1:0] active;

`ifdef PULSE_STRETCH_SYNC_EN
   logic [CHANNELS-1:0] sync_meta;
   logic [CHANNELS-1:0] sync_stable;

   // Synchronizers reset high so an input already high at reset release
   // is not mistaken for a rising edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_meta   <= '1;
         sync_stable <= '1;
      end else begin
         sync_meta   <= pulse_in;
         sync_stable <= sync_meta;
      end
   end

   assign pulse_sync = sync_stable;
`else
   assign pulse_sync = pulse_in;
`endif

   // Edge detector history; resets high for the same reason as above.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prev <= '1;
      end else begin
         prev <= pulse_sync;
      end
   end

   assign trig = pulse_sync & ~prev;

   for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
      stretch_channel #(
         .CNT_W   (CNT_W),
         .HOLDOFF (HOLDOFF)
      ) u_chan (
         .clk         (clk),
         .rst         (rst),
         .trig        (trig[i]),
         .len         (len),
         .retrig      (retrig),
         .clr_dropped (clr_dropped),
         .pulse_out   (pulse_out[i]),
         .done        (done[i]),
         .dropped     (dropped[i]),
         .active      (active[i])
      );
   end

   assign busy = |active;

endmodule

// File: tb/tb_multi_pulse_stretcher.sv
// ---------------------------------------------------------------------------
// tb_multi_pulse_stretcher
// Drives two stretchers (no hold-off and HOLDOFF = 3, both CNT_W = 4) with
// identical directed and random stimulus. A behavioural model counting
// remaining high / hold-off cycles per channel predicts every cycle's
// outputs; a monitor pops the predictions and compares.
// ---------------------------------------------------------------------------
module tb_multi_pulse_stretcher;

   localparam int CHANNELS = 4;
   localparam int CNT_W    = 4;
   localparam int NDUT     = 2;
   localparam int HOLD_A   = 0;
   localparam int HOLD_B   = 3;

   logic                clk = 1'b0;
   logic                rst;
   logic [CHANNELS-1:0] pulse_in;
   logic [CNT_W-1:0]    len;
   logic                retrig;
   logic                clr_dropped;

   logic [CHANNELS-1:0] pulse_out_a, done_a, dropped_a;
   logic [CHANNELS-1:0] pulse_out_b, done_b, dropped_b;
   logic                busy_a, busy_b;

   typedef struct packed {
      logic [CHANNELS-1:0] pulse_out;
      logic [CHANNELS-1:0] done;
      logic [CHANNELS-1:0] dropped;
      logic                busy;
   } obs_t;

   obs_t exp_q_a[$];
   obs_t exp_q_b[$];

   int tests  = 0;
   int failed = 0;
   int cyc    = 0;

   // Reference model state: cycles of high output still to come (including
   // the current one) and hold-off cycles still to come, per DUT/channel.
   int                  hi_left [NDUT][CHANNELS];
   int                  ho_left [NDUT][CHANNELS];
   logic [CHANNELS-1:0] m_prev;
   logic [CHANNELS-1:0] m_dropped [NDUT];

   always #5 clk = ~clk;

   multi_pulse_stretcher #(
      .CHANNELS (CHANNELS),
      .CNT_W    (CNT_W),
      .HOLDOFF  (HOLD_A)
   ) dut_a (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in),
      .len         (len),
      .retrig      (retrig),
      .clr_dropped (clr_dropped),
      .pulse_out   (pulse_out_a),
      .done        (done_a),
      .dropped     (dropped_a),
      .busy        (busy_a)
   );

   multi_pulse_stretcher #(
      .CHANNELS (CHANNELS),
      .CNT_W    (CNT_W),
      .HOLDOFF  (HOLD_B)
   ) dut_b (
      .clk         (clk),
      .rst         (rst),
      .pulse_in    (pulse_in),
      .len         (len),
      .retrig      (retrig),
      .clr_dropped (clr_dropped),
      .pulse_out   (pulse_out_b),
      .done        (done_b),
      .dropped     (dropped_b),
      .busy        (busy_b)
   );

   function automatic int hold_of(input int d);
      return (d == 0) ? HOLD_A : HOLD_B;
   endfunction

   function automatic int len_cycles(input logic [CNT_W-1:0] l);
      return (l == '0) ? (1 << CNT_W) : int'(l);
   endfunction

   task automatic model_reset();
      for (int d = 0; d < NDUT; d++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            hi_left[d][c] = 0;
            ho_left[d][c] = 0;
         end
         m_dropped[d] = '0;
      end
      m_prev = '1;
   endtask

   // Advance the model across one clock edge using the inputs held before it.
   task automatic model_edge();
      logic [CHANNELS-1:0] t;
      logic                drop;
      t = pulse_in & ~m_prev;
      for (int d = 0; d < NDUT; d++) begin
         for (int c = 0; c < CHANNELS; c++) begin
            drop = 1'b0;
            if (hi_left[d][c] > 0) begin
               if (t[c] && retrig) begin
                  hi_left[d][c] = len_cycles(len);
               end else begin
                  drop = t[c];
                  hi_left[d][c] = hi_left[d][c] - 1;
                  if (hi_left[d][c] == 0) ho_left[d][c] = hold_of(d);
               end
            end else if (ho_left[d][c] > 0) begin
               drop = t[c];
               ho_left[d][c] = ho_left[d][c] - 1;
            end else if (t[c]) begin
               hi_left[d][c] = len_cycles(len);
            end
            if (drop) m_dropped[d][c] = 1'b1;
            else if (clr_dropped) m_dropped[d][c] = 1'b0;
         end
      end
      m_prev = pulse_in;
   endtask

   function automatic obs_t model_expect(input int d);
      obs_t                e;
      logic [CHANNELS-1:0] t;
      t = pulse_in & ~m_prev;
      e.busy = 1'b0;
      for (int c = 0; c < CHANNELS; c++) begin
         e.pulse_out[c] = (hi_left[d][c] > 0);
         e.done[c]      = (hi_left[d][c] == 1) && !(t[c] && retrig);
         if (hi_left[d][c] > 0 || ho_left[d][c] > 0) e.busy = 1'b1;
      end
      e.dropped = m_dropped[d];
      return e;
   endfunction

   task automatic push_expect();
      exp_q_a.push_back(model_expect(0));
      exp_q_b.push_back(model_expect(1));
   endtask

   task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
      tests++;
      if (got !== want) begin
         failed++;
         $display("[TB] FAIL %s cycle=%0d got=%0h want=%0h", name, cyc, got, want);
      end
   endtask

   task automatic checkOutput(input string tag, input obs_t e, input obs_t a);
      cmp({tag, ".pulse_out"}, 32'(a.pulse_out), 32'(e.pulse_out));
      cmp({tag, ".done"},      32'(a.done),      32'(e.done));
      cmp({tag, ".dropped"},   32'(a.dropped),   32'(e.dropped));
      cmp({tag, ".busy"},      32'(a.busy),      32'(e.busy));
   endtask

   // One clock cycle: model crosses the edge, new inputs are driven just
   // after it, and the prediction for this cycle is queued.
   task automatic applyStimulus(input logic [CHANNELS-1:0] in, input logic [CNT_W-1:0] l,
                                input logic rt, input logic clr);
      @(posedge clk);
      if (!rst) model_edge();
      #1;
      pulse_in    = in;
      len         = l;
      retrig      = rt;
      clr_dropped = clr;
      if (!rst) push_expect();
   endtask

   task automatic idle(input int n, input logic [CNT_W-1:0] l, input logic rt);
      for (int i = 0; i < n; i++) applyStimulus('0, l, rt, 1'b0);
   endtask

   task automatic resetPulse(input logic [CHANNELS-1:0] held, input int cycles);
      rst         = 1'b1;
      model_reset();
      pulse_in    = held;
      clr_dropped = 1'b0;
      repeat (cycles) @(posedge clk);
      #1;
      rst = 1'b0;
      push_expect();
   endtask

   // Monitor: compares each cycle's DUT outputs against the queued prediction.
   initial begin
      obs_t act;
      forever begin
         @(negedge clk);
         cyc++;
         if (rst) begin
            exp_q_a.delete();
            exp_q_b.delete();
         end else begin
            if (exp_q_a.size() > 0) begin
               act.pulse_out = pulse_out_a;
               act.done      = done_a;
               act.dropped   = dropped_a;
               act.busy      = busy_a;
               checkOutput("a", exp_q_a.pop_front(), act);
            end
            if (exp_q_b.size() > 0) begin
               act.pulse_out = pulse_out_b;
               act.done      = done_b;
               act.dropped   = dropped_b;
               act.busy      = busy_b;
               checkOutput("b", exp_q_b.pop_front(), act);
            end
         end
      end
   end

   // Watchdog so the run always ends.
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [CHANNELS-1:0] rin;
      logic [CNT_W-1:0]    rlen;
      logic                rrt;

      pulse_in    = '0;
      len         = 4'd5;
      retrig      = 1'b0;
      clr_dropped = 1'b0;
      resetPulse('0, 3);

      // Single edge, len 5.
      idle(3, 4'd5, 1'b0);
      applyStimulus(4'b0001, 4'd5, 1'b0, 1'b0);
      idle(10, 4'd5, 1'b0);

      // len 0 gives 16 cycles; all channels triggered together.
      applyStimulus(4'b1111, 4'd0, 1'b0, 1'b0);
      idle(22, 4'd0, 1'b0);

      // Retriggerable: second edge 4 cycles later extends to 12 cycles.
      applyStimulus(4'b0001, 4'd8, 1'b1, 1'b0);
      idle(3, 4'd8, 1'b1);
      applyStimulus(4'b0001, 4'd8, 1'b1, 1'b0);
      idle(16, 4'd8, 1'b1);

      // Non-retriggerable: second edge dropped.
      applyStimulus(4'b0001, 4'd8, 1'b0, 1'b0);
      idle(3, 4'd8, 1'b0);
      applyStimulus(4'b0001, 4'd8, 1'b0, 1'b0);
      idle(12, 4'd8, 1'b0);
      applyStimulus('0, 4'd8, 1'b0, 1'b1);
      idle(2, 4'd8, 1'b0);
      // Drop and clear in the same cycle: flag must stay set.
      applyStimulus(4'b0001, 4'd8, 1'b0, 1'b0);
      idle(2, 4'd8, 1'b0);
      applyStimulus(4'b0001, 4'd8, 1'b0, 1'b1);
      idle(14, 4'd8, 1'b0);
      applyStimulus('0, 4'd8, 1'b0, 1'b1);

      // len 2: edge inside hold-off window, then edge on first idle cycle.
      idle(2, 4'd2, 1'b0);
      applyStimulus(4'b0010, 4'd2, 1'b0, 1'b0);
      idle(2, 4'd2, 1'b0);
      applyStimulus(4'b0010, 4'd2, 1'b0, 1'b0);
      idle(2, 4'd2, 1'b0);
      applyStimulus(4'b0010, 4'd2, 1'b0, 1'b0);
      idle(8, 4'd2, 1'b0);

      // Asynchronous reset in the middle of a 10-cycle pulse.
      applyStimulus(4'b0100, 4'd10, 1'b0, 1'b0);
      idle(3, 4'd10, 1'b0);
      #2;
      rst = 1'b1;
      #1;
      cmp("async_rst.pulse_out_a", 32'(pulse_out_a), 32'd0);
      cmp("async_rst.pulse_out_b", 32'(pulse_out_b), 32'd0);
      cmp("async_rst.done_a",      32'(done_a),      32'd0);
      cmp("async_rst.busy_b",      32'(busy_b),      32'd0);
      // Input held high across reset release must not trigger.
      resetPulse(4'b0001, 2);
      for (int i = 0; i < 4; i++) applyStimulus(4'b0001, 4'd3, 1'b0, 1'b0);
      idle(1, 4'd3, 1'b0);
      applyStimulus(4'b0001, 4'd3, 1'b0, 1'b0);
      idle(8, 4'd3, 1'b0);

      // Random traffic with changing length, mode and clears.
      rlen = 4'd3;
      rrt  = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         for (int c = 0; c < CHANNELS; c++) rin[c] = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 15) == 0) rlen = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 39) == 0) rrt = ~rrt;
         applyStimulus(rin, rlen, rrt, ($urandom_range(0, 15) == 0));
      end
      idle(40, rlen, rrt);

      @(negedge clk);
      #1;
      cmp("queue_a.drained", 32'(exp_q_a.size()), 32'd0);
      cmp("queue_b.drained", 32'(exp_q_b.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
